// File: rtl/disp_write_arbiter.sv
// disp_write_arbiter
//   Shares the single write port (write/sel/num) of the 8-digit seven-segment
//   display between two requesters, A and B, using round-robin arbitration.
//   After every requester write, GAP idle cycles pass before the next grant so
//   the display scan is never held on one digit. An optional clear sequence
//   writes 0 to all eight digits back to back.
//
//   Optional feature macro: DISP_ARB_CLEAR_EN
//     defined   -> CLEAR state present; clear_start and clear_busy are live
//     undefined -> clear_start ignored; clear_busy tied low
//
//   Ready outputs are combinational from registered state and the valids.
//   write/sel/num/clear_busy are registered.

module disp_write_arbiter #(
    parameter int unsigned GAP = 4
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       a_valid,
    input  logic [2:0] a_sel,
    input  logic [3:0] a_num,
    output logic       a_ready,

    input  logic       b_valid,
    input  logic [2:0] b_sel,
    input  logic [3:0] b_num,
    output logic       b_ready,

    input  logic       clear_start,
    output logic       clear_busy,

    output logic       write,
    output logic [2:0] sel,
    output logic [3:0] num
);

    // Gap counter must hold the value GAP; keep at least one bit when GAP = 0.
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

`ifdef DISP_ARB_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GAP_WAIT = 2'd1,
        CLEAR    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GAP_WAIT = 2'd1
    } state_t;
`endif

    state_t         state;
    logic [GW-1:0]  gap_cnt;
    logic           prio;       // 0: A has priority, 1: B has priority
    logic           clear_go;   // clear accepted this cycle
    logic           can_grant;

`ifdef DISP_ARB_CLEAR_EN
    logic [2:0]     clear_idx;  // next digit of the clear sequence to write

    // Clear is only accepted from IDLE; elsewhere the request is dropped.
    assign clear_go = (state == IDLE) && clear_start;
`else
    logic           unused_clear_start;

    assign unused_clear_start = clear_start;
    assign clear_go           = 1'b0;
    assign clear_busy         = 1'b0;
`endif

    // Grant window: idle, gap expired, and no clear taking the port this cycle.
    // NOTE: continuous assigns for combinational outputs cannot infer latches.
    assign can_grant = (state == IDLE) && (gap_cnt == '0) && !clear_go;
    assign a_ready   = can_grant && a_valid && (!b_valid || !prio);
    assign b_ready   = can_grant && b_valid && (!a_valid ||  prio);

    // Arbitration/gap/clear FSM with registered display-port outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            prio       <= 1'b0;
            write      <= 1'b0;
            sel        <= 3'd0;
            num        <= 4'd0;
`ifdef DISP_ARB_CLEAR_EN
            clear_idx  <= 3'd0;
            clear_busy <= 1'b0;
`endif
        end else begin
            // write is a single-cycle strobe unless re-armed below
            write <= 1'b0;

            case (state)
                IDLE: begin
`ifdef DISP_ARB_CLEAR_EN
                    if (clear_go) begin
                        write      <= 1'b1;
                        sel        <= 3'd0;
                        num        <= 4'd0;
                        clear_idx  <= 3'd1;
                        clear_busy <= 1'b1;
                        state      <= CLEAR;
                    end else
`endif
                    if (a_ready || b_ready) begin
                        write   <= 1'b1;
                        sel     <= a_ready ? a_sel : b_sel;
                        num     <= a_ready ? a_num : b_num;
                        // point at the side that was not granted
                        prio    <= a_ready;
                        gap_cnt <= GW'(GAP);
                        if (GAP != 0) begin
                            state <= GAP_WAIT;
                        end
                    end
                end

                GAP_WAIT: begin
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

`ifdef DISP_ARB_CLEAR_EN
                CLEAR: begin
                    // clear_idx wraps 7 -> 0 only after the sel=7 write is issued
                    if (clear_idx != 3'd0) begin
                        write     <= 1'b1;
                        sel       <= clear_idx;
                        num       <= 4'd0;
                        clear_idx <= clear_idx + 3'd1;
                    end else begin
                        clear_busy <= 1'b0;
                        gap_cnt    <= GW'(GAP);
                        state      <= (GAP != 0) ? GAP_WAIT : IDLE;
                    end
                end
`endif

                default: begin
                    state   <= IDLE;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_write_arbiter.sv
// Directed bench for disp_write_arbiter: one instance with GAP=4, one with
// GAP=0, sharing clock, reset and requester inputs. Clear tests run when
// DISP_ARB_CLEAR_EN is defined; otherwise clear_start must be ignored.

module tb_disp_write_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, b_valid, clear_start;
    logic [2:0] a_sel, b_sel;
    logic [3:0] a_num, b_num;

    logic       ar4, br4, cb4, w4;
    logic [2:0] s4;
    logic [3:0] n4;
    logic       ar0, br0, cb0, w0;
    logic [2:0] s0;
    logic [3:0] n0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    disp_write_arbiter #(.GAP(4)) u_gap4 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_sel(a_sel), .a_num(a_num), .a_ready(ar4),
        .b_valid(b_valid), .b_sel(b_sel), .b_num(b_num), .b_ready(br4),
        .clear_start(clear_start), .clear_busy(cb4),
        .write(w4), .sel(s4), .num(n4)
    );

    disp_write_arbiter #(.GAP(0)) u_gap0 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_sel(a_sel), .a_num(a_num), .a_ready(ar0),
        .b_valid(b_valid), .b_sel(b_sel), .b_num(b_num), .b_ready(br0),
        .clear_start(clear_start), .clear_busy(cb0),
        .write(w0), .sel(s0), .num(n0)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid     = 1'b0;
        b_valid     = 1'b0;
        clear_start = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        reset       = 1'b0;
    endtask

    initial begin
        int n;
        int wcnt;
        int wcyc [8];
        int wsel [8];
        int wnum [8];
        int busy_seen;

        a_sel = 3'd0; a_num = 4'd0; b_sel = 3'd0; b_num = 4'd0;
        do_reset();

        // ---- reset values
        check("rst_write",  w4,  0);
        check("rst_sel",    s4,  0);
        check("rst_num",    n4,  0);
        check("rst_busy",   cb4, 0);
        check("rst_aready", ar4, 0);
        check("rst_bready", br4, 0);
        check("rst_write0", w0,  0);

        // ---- single A request
        a_valid = 1'b1; a_sel = 3'd3; a_num = 4'd9;
        #1;
        check("t1_aready", ar4, 1);
        check("t1_bready", br4, 0);
        tick();
        a_valid = 1'b0;
        check("t1_write", w4, 1);
        check("t1_sel",   s4, 3);
        check("t1_num",   n4, 9);
        check("t1_bready_after", br4, 0);
        tick();
        check("t1_pulse_end", w4, 0);

        // ---- A and B continuously valid, GAP=4
        do_reset();
        a_valid = 1'b1; a_sel = 3'd1; a_num = 4'd5;
        b_valid = 1'b1; b_sel = 3'd2; b_num = 4'd6;
        #1;
        wcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            check("t2_one_ready", int'(ar4 & br4), 0);
            tick();
            if (w4 && wcnt < 8) begin
                wcyc[wcnt] = k;
                wsel[wcnt] = int'(s4);
                wnum[wcnt] = int'(n4);
                wcnt++;
            end
        end
        check("t2_write_count", wcnt, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_cycle%0d", i), wcyc[i], 1 + 5 * i);
            check($sformatf("t2_sel%0d", i),   wsel[i], (i % 2 == 0) ? 1 : 2);
            check($sformatf("t2_num%0d", i),   wnum[i], (i % 2 == 0) ? 5 : 6);
        end

        // ---- GAP=0, only B valid for 4 cycles
        do_reset();
        b_valid = 1'b1; b_sel = 3'd4; b_num = 4'd7;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_bready%0d", i), br0, 1);
            check($sformatf("t3_aready%0d", i), ar0, 0);
            tick();
            if (i == 3) b_valid = 1'b0;
            check($sformatf("t3_write%0d", i), w0, 1);
            check($sformatf("t3_sel%0d", i),   s0, 4);
            check($sformatf("t3_num%0d", i),   n0, 7);
        end
        tick();
        check("t3_write_end", w0, 0);

        // ---- clear_start in IDLE with A valid
        do_reset();
        a_valid = 1'b1; a_sel = 3'd1; a_num = 4'd5;
        clear_start = 1'b1;
        #1;
`ifdef DISP_ARB_CLEAR_EN
        check("t4_aready_blocked", ar4, 0);
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t4_write%0d", k), w4, 1);
            check($sformatf("t4_sel%0d", k),   s4, k);
            check($sformatf("t4_num%0d", k),   n4, 0);
            check($sformatf("t4_busy%0d", k),  cb4, 1);
            check($sformatf("t4_ar%0d", k),    ar4, 0);
            tick();
        end
        check("t4_write_done", w4, 0);
        check("t4_busy_done",  cb4, 0);
        n = 0;
        while (!ar4 && n < 20) begin
            tick();
            n++;
        end
        check("t4_grant_delay", n, 4);
        tick();
        a_valid = 1'b0;
        check("t4_a_write", w4, 1);
        check("t4_a_sel",   s4, 1);
        check("t4_a_num",   n4, 5);
`else
        check("t4_aready_nocl", ar4, 1);
        tick();
        a_valid = 1'b0;
        clear_start = 1'b0;
        check("t4_busy_nocl", cb4, 0);
        check("t4_write_nocl", w4, 1);
        check("t4_sel_nocl",   s4, 1);
`endif

        // ---- clear_start during GAP_WAIT is ignored
        do_reset();
        a_valid = 1'b1; a_sel = 3'd3; a_num = 4'd9;
        #1;
        check("t5_first_grant", ar4, 1);
        tick();
        a_valid = 1'b0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        a_valid = 1'b1; a_sel = 3'd6; a_num = 4'd2;
        #1;
        check("t5_no_clear_write", w4, 0);
        busy_seen = 0;
        n = 0;
        while (!ar4 && n < 20) begin
            busy_seen |= int'(cb4);
            tick();
            n++;
        end
        check("t5_grant_delay", n, 3);
        check("t5_no_busy", busy_seen, 0);
        tick();
        a_valid = 1'b0;
        check("t5_write", w4, 1);
        check("t5_sel",   s4, 6);
        check("t5_num",   n4, 2);
        check("t5_busy_after", cb4, 0);

        // ---- reset mid-gap restores prio=A and clears the gap
        do_reset();
        a_valid = 1'b1; a_sel = 3'd1; a_num = 4'd5;
        #1;
        tick();
        a_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_gap_rst_write", w4, 0);
        check("t6_gap_rst_sel",   s4, 0);
        check("t6_gap_rst_num",   n4, 0);
        a_valid = 1'b1; a_sel = 3'd1; a_num = 4'd5;
        b_valid = 1'b1; b_sel = 3'd2; b_num = 4'd6;
        #1;
        check("t6_gap_rst_aready", ar4, 1);
        check("t6_gap_rst_bready", br4, 0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("t6_gap_rst_sel_w", s4, 1);

`ifdef DISP_ARB_CLEAR_EN
        // ---- reset after the 3rd clear write
        do_reset();
        clear_start = 1'b1;
        #1;
        tick();
        clear_start = 1'b0;
        check("t7_clr_sel0", s4, 0);
        tick();
        tick();
        check("t7_clr_write3", w4, 1);
        check("t7_clr_sel2",   s4, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_rst_write", w4, 0);
        check("t7_rst_busy",  cb4, 0);
        check("t7_rst_sel",   s4, 0);
        tick();
        check("t7_abandoned", w4, 0);
        a_valid = 1'b1; a_sel = 3'd3; a_num = 4'd9;
        b_valid = 1'b1; b_sel = 3'd2; b_num = 4'd6;
        #1;
        check("t7_aready", ar4, 1);
        check("t7_bready", br4, 0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("t7_write", w4, 1);
        check("t7_sel",   s4, 3);
        check("t7_num",   n4, 9);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/disp_write_arbiter.md
# disp_write_arbiter

Write-side controller for the 8-digit seven-segment display block: shares the display's single write port (write, sel, num) between two requesters with round-robin arbitration. Enforces a programmable idle gap between writes so the display scan is not held on one digit. Optionally sequences a full-display clear. Sits between user-input and autonomous digit sources and the display block, whose write/sel/num inputs it drives directly.

## Interface
- GAP, default 4: idle cycles enforced after each requester write before the next grant (0 = back-to-back allowed)
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- a_valid  in  1  requester A has a write pending
- a_sel  in  3  requester A target digit
- a_num  in  4  requester A digit value
- a_ready  out  1  requester A accepted this cycle
- b_valid / b_sel / b_num  in  1/3/4  requester B, same meaning
- b_ready  out  1  requester B accepted this cycle
- clear_start  in  1  request clear of all digits (compiled-in feature only)
- clear_busy  out  1  clear sequence in progress
- write  out  1  write strobe to display, registered
- sel  out  3  digit index to display, registered
- num  out  4  digit value to display, registered

## Operation
- States: IDLE, GAP_WAIT, CLEAR.
- Handshake: transfer when x_valid && x_ready in the same cycle; x_ready is combinational from registered state and valids, never depends on x_ready. Requesters hold sel/num stable while valid and not ready.
- Grant only in IDLE, gap counter 0, clear not starting. At most one ready high per cycle.
- Round-robin: priority pointer prio (reset = A). Both valid -> grant prio side. One valid -> grant it. After any grant, prio points to the non-granted side.
- On grant: next cycle write=1, sel/num = granted requester's values. write is a single-cycle pulse per transfer.
- After a requester write: GAP>0 -> enter GAP_WAIT, counter loaded with GAP, decrements each cycle, return to IDLE when reaching 0 (exactly GAP cycles with no grant). GAP=0 -> stay IDLE, grant allowed the cycle after the previous grant.
- CLEAR: entered when clear_start=1 in IDLE; clear_start has priority over pending valids in that cycle (no ready). Issues 8 consecutive write pulses, sel = 0,1,...,7, num = 0; GAP not applied between them. clear_busy high from the cycle after clear_start through the cycle of the sel=7 write. Then GAP_WAIT (GAP>0) or IDLE.
- clear_start in GAP_WAIT or CLEAR: ignored (not queued).
- Sel wrap: internal 3-bit clear index wraps 7->0 only at sequence end; no other arithmetic.

## Timing
- Reset values: write=0, sel=0, num=0, a_ready=0, b_ready=0, clear_busy=0, prio=A, state IDLE, gap counter 0.
- Latency handshake -> write pulse: 1 cycle.
- Max requester throughput: one write per GAP+1 cycles.
- Clear: clear_start at cycle t -> writes at t+1..t+8; next grant earliest t+9+GAP.
- Reset asserted mid-clear or mid-gap: next cycle all outputs at reset values, sequence abandoned, no further writes.
- Valid dropped before ready: no transfer, no state change.

## Configuration
- DISP_ARB_CLEAR_EN defined: CLEAR state, clear_start and clear_busy function as above.
- Not defined: clear_start ignored, clear_busy tied 0, CLEAR state absent; arbitration and gap behaviour unchanged.

## Test plan
- Reset, then A valid sel=3 num=9 alone -> a_ready=1 one cycle, next cycle write=1 sel=3 num=9, b_ready stays 0.
- A and B valid continuously (A sel=1 num=5, B sel=2 num=6), GAP=4 -> writes alternate A,B,A,B starting with A, spaced exactly 5 cycles apart.
- GAP=0, only B valid for 4 cycles -> write high 4 consecutive cycles, one b_ready per write.
- clear_start in IDLE with A valid (DISP_ARB_CLEAR_EN) -> a_ready=0, 8 writes sel 0..7 num 0, clear_busy high 8 cycles, A granted after the gap.
- clear_start during GAP_WAIT -> no clear, no clear_busy; normal grant resumes after gap.
- reset after 3rd clear write -> write=0, clear_busy=0, sel=0 next cycle; following A request serviced with prio=A.
